cdb_arbiter: RTL and testbench

Arbitrates the two result producers of the out-of-order core, ALU and load/store buffer, onto a single registered common data bus (CDB) consumed by Rob, Rs, lsBuffer and dispatcher. Each producer pushes into its own small FIFO. A round-robin scheduler drains one entry per cycle onto the CDB. Sits between `ALU`/`lsBuffer` and all broadcast consumers, and is flushed by the ROB `clear` signal.

---
 rtl/cdb_pkg.sv | 20 ++
 rtl/cdb_fifo.sv | 51 +++++
 rtl/cdb_arbiter.sv | 137 +++++++++++++
 tb/tb_cdb_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types for the common data bus arbiter: source encoding and the broadcast entry.
// Entry widths are fixed here; cdb_arbiter defaults its DATA_W/TAG_W to these values.
package cdb_pkg;

    localparam int CDB_DATA_W = 32;
    localparam int CDB_TAG_W  = 4;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_t;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] val;
        logic                  is_jump;
        logic [CDB_DATA_W-1:0] jump_pc;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Small power-of-two FIFO with wrapping pointers and a separate occupancy count.
// The caller guarantees push only when not full and pop only when not empty.
module cdb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would race.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the count alone decides validity, so this maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (rst && push && !flush) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter of ALU and load/store results onto one registered CDB.
// Define CDB_BYPASS_EN to let an entry skip its FIFO when both FIFOs are empty.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_W = CDB_DATA_W,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_val,
    input  logic              alu_is_jump,
    input  logic [DATA_W-1:0] alu_jump_pc,
    output logic              alu_ready,
    input  logic              lsb_valid,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [DATA_W-1:0] lsb_val,
    output logic              lsb_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_val,
    output logic              cdb_is_jump,
    output logic [DATA_W-1:0] cdb_jump_pc,
    output logic              cdb_src
);

    localparam int              CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    cdb_entry_t       alu_in, lsb_in, alu_head, lsb_head, grant_entry;
    logic [CNT_W-1:0] alu_count, lsb_count;
    logic             alu_empty, lsb_empty;
    logic             alu_push, lsb_push, alu_pop, lsb_pop, flush;
    logic             grant_valid, grant_byp;
    src_t             grant_src, last_grant, rr_pick;

    // Load/store entries carry no branch information.
    assign alu_in = '{tag: alu_tag, val: alu_val, is_jump: alu_is_jump, jump_pc: alu_jump_pc};
    assign lsb_in = '{tag: lsb_tag, val: lsb_val, is_jump: 1'b0, jump_pc: '0};

    assign alu_empty = (alu_count == '0);
    assign lsb_empty = (lsb_count == '0);
    assign alu_ready = rst && rdy && (alu_count < FULL);
    assign lsb_ready = rst && rdy && (lsb_count < FULL);
    assign flush     = clear && rdy;
    assign rr_pick   = (last_grant == SRC_ALU) ? SRC_LSB : SRC_ALU;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        alu_push    = alu_valid && alu_ready && !clear;
        lsb_push    = lsb_valid && lsb_ready && !clear;
        grant_valid = 1'b0;
        grant_byp   = 1'b0;
        grant_src   = SRC_ALU;
        if (!alu_empty && !lsb_empty) begin
            grant_valid = 1'b1;
            grant_src   = rr_pick;
        end else if (!alu_empty) begin
            grant_valid = 1'b1;
            grant_src   = SRC_ALU;
        end else if (!lsb_empty) begin
            grant_valid = 1'b1;
            grant_src   = SRC_LSB;
        end
`ifdef CDB_BYPASS_EN
        else if (alu_push || lsb_push) begin
            grant_valid = 1'b1;
            grant_byp   = 1'b1;
            if (alu_push && lsb_push) grant_src = rr_pick;
            else if (lsb_push)        grant_src = SRC_LSB;
            // The bypassed entry goes straight to the bus; only the loser is queued.
            if (grant_src == SRC_ALU) alu_push = 1'b0;
            else                      lsb_push = 1'b0;
        end
`endif
        alu_pop = grant_valid && !grant_byp && (grant_src == SRC_ALU) && rdy && !clear;
        lsb_pop = grant_valid && !grant_byp && (grant_src == SRC_LSB) && rdy && !clear;
        if (grant_byp) grant_entry = (grant_src == SRC_ALU) ? alu_in : lsb_in;
        else           grant_entry = (grant_src == SRC_ALU) ? alu_head : lsb_head;
    end

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH($bits(cdb_entry_t))) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (alu_push),
        .pop   (alu_pop),
        .flush (flush),
        .din   (alu_in),
        .dout  (alu_head),
        .count (alu_count)
    );

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH($bits(cdb_entry_t))) u_lsb_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (lsb_push),
        .pop   (lsb_pop),
        .flush (flush),
        .din   (lsb_in),
        .dout  (lsb_head),
        .count (lsb_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_valid   <= 1'b0;
            cdb_tag     <= '0;
            cdb_val     <= '0;
            cdb_is_jump <= 1'b0;
            cdb_jump_pc <= '0;
            cdb_src     <= SRC_ALU;
            last_grant  <= SRC_LSB;
        end else if (rdy) begin
            if (clear) begin
                // Parking on LSB hands the first post-flush tie to the ALU.
                cdb_valid  <= 1'b0;
                last_grant <= SRC_LSB;
            end else if (grant_valid) begin
                cdb_valid   <= 1'b1;
                cdb_tag     <= grant_entry.tag;
                cdb_val     <= grant_entry.val;
                cdb_is_jump <= grant_entry.is_jump;
                cdb_jump_pc <= grant_entry.jump_pc;
                cdb_src     <= grant_src;
                last_grant  <= grant_src;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (default build, no bypass): reset, latency, clear,
// streaming with full FIFOs and a rdy stall, and reset with queued entries.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        alu_valid, alu_is_jump, alu_ready;
    logic [3:0]  alu_tag;
    logic [31:0] alu_val, alu_jump_pc;
    logic        lsb_valid, lsb_ready;
    logic [3:0]  lsb_tag;
    logic [31:0] lsb_val;
    logic        cdb_valid, cdb_is_jump, cdb_src;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val, cdb_jump_pc;

    int errors = 0;
    int checks = 0;
    int exp_tag [1:20];

    always #5 clk = ~clk;

    cdb_arbiter #(.DATA_W(32), .TAG_W(4), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .clear       (clear),
        .alu_valid   (alu_valid),
        .alu_tag     (alu_tag),
        .alu_val     (alu_val),
        .alu_is_jump (alu_is_jump),
        .alu_jump_pc (alu_jump_pc),
        .alu_ready   (alu_ready),
        .lsb_valid   (lsb_valid),
        .lsb_tag     (lsb_tag),
        .lsb_val     (lsb_val),
        .lsb_ready   (lsb_ready),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_val     (cdb_val),
        .cdb_is_jump (cdb_is_jump),
        .cdb_jump_pc (cdb_jump_pc),
        .cdb_src     (cdb_src)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ALU value 0x100+tag, jump flag tag[0], target 0x4000+tag; LSB value 0x200+tag.
    function automatic logic [31:0] vof(input int tag);
        return (tag < 8) ? 32'h100 + 32'(tag) : 32'h200 + 32'(tag);
    endfunction

    task automatic drive(input logic av, input logic [3:0] at, input logic lv, input logic [3:0] lt);
        alu_valid   = av;
        alu_tag     = at;
        alu_val     = 32'h100 + 32'(at);
        alu_is_jump = at[0];
        alu_jump_pc = 32'h4000 + 32'(at);
        lsb_valid   = lv;
        lsb_tag     = lt;
        lsb_val     = 32'h200 + 32'(lt);
    endtask

    task automatic expect_cdb(input string name, input int tag, input logic [31:0] val);
        logic is_lsb;
        is_lsb = (tag >= 8);
        check({name, ".valid"}, 32'(cdb_valid), 32'd1);
        check({name, ".tag"},   32'(cdb_tag), 32'(tag));
        check({name, ".src"},   32'(cdb_src), 32'(is_lsb));
        check({name, ".val"},   cdb_val, val);
        check({name, ".jump"},  32'(cdb_is_jump), is_lsb ? 32'd0 : 32'(tag & 1));
        check({name, ".jpc"},   cdb_jump_pc, is_lsb ? 32'd0 : 32'h4000 + 32'(tag));
    endtask

    task automatic expect_idle(input string name);
        check({name, ".valid"}, 32'(cdb_valid), 32'd0);
    endtask

    task automatic expect_zero_outputs(input string name);
        expect_idle(name);
        check({name, ".tag"},  32'(cdb_tag), 32'd0);
        check({name, ".val"},  cdb_val, 32'd0);
        check({name, ".jump"}, 32'(cdb_is_jump), 32'd0);
        check({name, ".jpc"},  cdb_jump_pc, 32'd0);
        check({name, ".src"},  32'(cdb_src), 32'd0);
        check({name, ".aready"}, 32'(alu_ready), 32'd0);
        check({name, ".lready"}, 32'(lsb_ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_tag = '{-1, 0, 8, 1, 9, 2, 10, 3, 11, 11, 11, 11, 11, 11, 4, 12, 5, 13, 6, -1};
        rst = 1'b0; rdy = 1'b1; clear = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 4'd0);

        // Reset state
        tick(); tick();
        expect_zero_outputs("reset");
        rst = 1'b1;
        #1;
        check("reset.aready_after", 32'(alu_ready), 32'd1);
        check("reset.lready_after", 32'(lsb_ready), 32'd1);

        // Two-edge latency: push at edge 1, broadcast after edge 2
        drive(1'b1, 4'd3, 1'b0, 4'd0);
        alu_val = 32'h10;
        tick();
        expect_idle("lat.e1");
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        expect_cdb("lat.e2", 3, 32'h10);
        tick();
        expect_idle("lat.e3");

        // Clear with queued entries and a concurrent push (tag 7) that must be dropped
        drive(1'b1, 4'd1, 1'b1, 4'd9);
        tick();
        drive(1'b1, 4'd2, 1'b1, 4'd10);
        tick();
        expect_cdb("clr.e2", 9, vof(9));
        drive(1'b1, 4'd3, 1'b0, 4'd0);
        tick();
        expect_cdb("clr.e3", 1, vof(1));
        drive(1'b1, 4'd7, 1'b1, 4'd12);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_idle("clr.e4");
        check("clr.e4.aready", 32'(alu_ready), 32'd1);
        check("clr.e4.lready", 32'(lsb_ready), 32'd1);
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        expect_idle("clr.e5");
        drive(1'b1, 4'd5, 1'b1, 4'd13);
        tick();
        expect_idle("clr.e6");
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        expect_cdb("clr.e7", 5, vof(5));
        tick();
        expect_cdb("clr.e8", 13, vof(13));
        tick();
        expect_idle("clr.e9");

        // Both sources push every cycle until LSB fills; rdy low for edges 10..14
        drive(1'b1, 4'd0, 1'b1, 4'd8);
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (exp_tag[e] < 0) expect_idle($sformatf("strm.e%0d", e));
            else expect_cdb($sformatf("strm.e%0d", e), exp_tag[e], vof(exp_tag[e]));
            if (e == 6) check("strm.e6.lready", 32'(lsb_ready), 32'd0);
            if (e == 7) begin
                check("strm.e7.lready", 32'(lsb_ready), 32'd1);
                check("strm.e7.aready", 32'(alu_ready), 32'd0);
            end
            if (e == 8) check("strm.e8.aready", 32'(alu_ready), 32'd1);
            if (e >= 10 && e <= 14) check($sformatf("strm.e%0d.aready", e), 32'(alu_ready), 32'd0);
            if (e < 7) drive(1'b1, 4'(e), 1'b1, 4'(8 + e));
            else       drive(1'b0, 4'd0, 1'b0, 4'd0);
            rdy = !(e >= 9 && e <= 13);
        end

        // Reset with both FIFOs non-empty and last grant on ALU
        drive(1'b1, 4'd1, 1'b1, 4'd9);
        tick();
        drive(1'b1, 4'd2, 1'b0, 4'd0);
        tick();
        expect_cdb("rr.e2", 9, vof(9));
        drive(1'b0, 4'd0, 1'b1, 4'd10);
        tick();
        expect_cdb("rr.e3", 1, vof(1));
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        rst = 1'b0;
        tick();
        expect_zero_outputs("rr.reset");
        rst = 1'b1;
        drive(1'b1, 4'd5, 1'b1, 4'd12);
        tick();
        expect_idle("rr.e5");
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        expect_cdb("rr.e6", 5, vof(5));
        tick();
        expect_cdb("rr.e7", 12, vof(12));
        tick();
        expect_idle("rr.e8");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
